// File: rtl/coin_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pkg
//  Description : Shared definitions for the coin input conditioner: channel
//                state encoding and the default debounce sample count.
//  Revision    : 1.0  initial release
// ============================================================================
package coin_pkg;

    // 20 ms of stable samples at 50 MHz
    localparam int unsigned CNT_MAX_DEFAULT = 999_999;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE    = 2'd0;
    localparam key_state_t ST_PRESS   = 2'd1;
    localparam key_state_t ST_HELD    = 2'd2;
    localparam key_state_t ST_RELEASE = 2'd3;

endpackage : coin_pkg
`default_nettype wire

// File: rtl/coin_pulse_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_gen_if
//  Description : Key / coin bundle between the raw push-keys, the coin
//                conditioner and the vending FSM.
//                key_one, key_half : raw active-low keys (asynchronous)
//                coin_one, coin_half : single-cycle coin pulses
//                busy : a key channel is still filtering or pressed
//  Revision    : 1.0  initial release
// ============================================================================
interface coin_pulse_gen_if;

    logic key_one;
    logic key_half;
    logic coin_one;
    logic coin_half;
    logic busy;

    // master: key source / coin consumer side
    modport master (
        output key_one,
        output key_half,
        input  coin_one,
        input  coin_half,
        input  busy
    );

    // slave: the conditioner itself
    modport slave (
        input  key_one,
        input  key_half,
        output coin_one,
        output coin_half,
        output busy
    );

endinterface : coin_pulse_gen_if
`default_nettype wire

// File: rtl/coin_pulse_gen_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One key channel: two-flop synchroniser, IDLE/PRESS/HELD/
//                RELEASE filter FSM and its stability counter.
//                sys_clk, sys_rst_n : clock, async active-low reset
//                key_n   : raw key, low = pressed
//                accept  : one-cycle strobe on an accepted press
//                active  : channel will be outside IDLE after this edge
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import coin_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  wire logic sys_clk,
    input  wire logic sys_rst_n,
    input  wire logic key_n,
    output logic      accept,
    output logic      active
);

    localparam int unsigned      CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             key_low;

    assign sync_d  = {sync_q[0], key_n};
    assign key_low = ~sync_q[1];

    // ------------------------------------------------------------------
    // State register (synchroniser resets to "released")
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (key_low) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_PRESS: begin
                if (!key_low) begin
                    // bounce during press: drop it without a pulse
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!key_low) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (key_low) begin
                    // release bounce: back to HELD, no new pulse
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs; active follows the next state so a registered copy of it
    // lines up exactly with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        accept = (state_q == ST_PRESS) && key_low && (cnt_q == CNT_LAST);
        active = (state_d != ST_IDLE);
    end

endmodule : key_debounce
`default_nettype wire

// File: rtl/coin_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pulse_gen
//  Description : Coin input conditioner. Debounces the one-yuan and
//                half-yuan keys and produces non-overlapping single-cycle
//                coin pulses for the vending FSM.
//                sys_clk, sys_rst_n : clock, async active-low reset
//                bus (slave)        : key inputs, coin_one / coin_half / busy
//  Revision    : 1.0  initial release
// ============================================================================
module coin_pulse_gen
    import coin_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    coin_pulse_gen_if.slave  bus
);

    logic acc_one;
    logic acc_half;
    logic act_one;
    logic act_half;

    logic coin_one_q;
    logic coin_one_d;
    logic coin_half_q;
    logic coin_half_d;
    logic pend_half_q;
    logic pend_half_d;
    logic busy_q;
    logic busy_d;

    key_debounce #(
        .CNT_MAX   (CNT_MAX)
    ) u_deb_one (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (bus.key_one),
        .accept    (acc_one),
        .active    (act_one)
    );

    key_debounce #(
        .CNT_MAX   (CNT_MAX)
    ) u_deb_half (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (bus.key_half),
        .accept    (acc_half),
        .active    (act_half)
    );

    // Arbiter: one-yuan wins a tie; the half accept is parked for one
    // cycle. A new accept cannot land on the drain cycle because both
    // channels have just entered HELD.
    always_comb begin
        coin_one_d  = acc_one;
        coin_half_d = pend_half_q | (acc_half & ~acc_one);
        pend_half_d = acc_half & acc_one;
        busy_d      = act_one | act_half | pend_half_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            coin_one_q  <= 1'b0;
            coin_half_q <= 1'b0;
            pend_half_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            coin_one_q  <= coin_one_d;
            coin_half_q <= coin_half_d;
            pend_half_q <= pend_half_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.coin_one  = coin_one_q;
    assign bus.coin_half = coin_half_q;
    assign bus.busy      = busy_q;

endmodule : coin_pulse_gen
`default_nettype wire
